// File: rtl/arith_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module      : arith_ctrl_pkg
// Description : Shared constants and types for the arith_ctrl sequencer.
//               Covers instruction field positions, opcodes, datapath select
//               codes, FSM state encoding and the decoded-instruction record.
// Revision    : 1.0 - initial release
// ============================================================================
package arith_ctrl_pkg;

  // Datapath and field widths
  localparam int DATA_W = 16;
  localparam int IMM_W  = 8;

  // Instruction field positions
  localparam int OP_HI    = 15;
  localparam int OP_LO    = 12;
  localparam int HALT_BIT = 11;
  localparam int IMM_HI   = 7;
  localparam int IMM_LO   = 0;

  // Opcodes
  localparam logic [3:0] OP_NOP = 4'h0;
  localparam logic [3:0] OP_LDR = 4'h1;
  localparam logic [3:0] OP_LDM = 4'h2;
  localparam logic [3:0] OP_LDI = 4'h3;
  localparam logic [3:0] OP_AND = 4'h4;
  localparam logic [3:0] OP_OR  = 4'h5;
  localparam logic [3:0] OP_ADD = 4'h6;
  localparam logic [3:0] OP_SUB = 4'h7;
  localparam logic [3:0] OP_IN  = 4'h8;
  localparam logic [3:0] OP_NOT = 4'h9;
  localparam logic [3:0] OP_INC = 4'hA;
  localparam logic [3:0] OP_DEC = 4'hB;
  localparam logic [3:0] OP_SHL = 4'hC;
  localparam logic [3:0] OP_SHR = 4'hD;
  localparam logic [3:0] OP_ROR = 4'hE;
  localparam logic [3:0] OP_SYS = 4'hF;  // HLT or JZ depending on IR[11]

  // Primary (out1) select codes
  localparam logic [2:0] SEL0_R   = 3'd0;
  localparam logic [2:0] SEL0_M   = 3'd1;
  localparam logic [2:0] SEL0_IMM = 3'd2;
  localparam logic [2:0] SEL0_AND = 3'd3;
  localparam logic [2:0] SEL0_OR  = 3'd4;
  localparam logic [2:0] SEL0_ADD = 3'd5;
  localparam logic [2:0] SEL0_SUB = 3'd6;
  localparam logic [2:0] SEL0_IN  = 3'd7;

  // Unary (out2) select codes
  localparam logic [2:0] SEL1_NOT = 3'd0;
  localparam logic [2:0] SEL1_INC = 3'd1;
  localparam logic [2:0] SEL1_DEC = 3'd2;
  localparam logic [2:0] SEL1_SHL = 3'd3;
  localparam logic [2:0] SEL1_SHR = 3'd4;
  localparam logic [2:0] SEL1_ROR = 3'd5;

  // Sequencer states
  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_FETCH  = 3'd1,
    ST_DECODE = 3'd2,
    ST_MEMRD  = 3'd3,
    ST_EXEC   = 3'd4,
    ST_HALT   = 3'd5
  } state_t;

  // Decoded view of one instruction
  typedef struct packed {
    logic [2:0] asel0;
    logic [2:0] asel1;
    logic       use_out2;
    logic       writes_a;
    logic       is_ldm;
    logic       is_hlt;
    logic       is_jz;
  } dec_t;

endpackage
`default_nettype wire

// File: rtl/arith_ctrl_decode.sv
`default_nettype none
// ============================================================================
// Module      : arith_ctrl_decode
// Description : Combinational opcode decoder. Maps opcode and halt bit to
//               the datapath selects and the sequencer control flags.
//               Macro ARITH_CTRL_JZ_EN: when undefined, opcode F with
//               IR[11]=0 decodes as a NOP (is_jz never asserted).
// Revision    : 1.0 - initial release
// ============================================================================
module arith_ctrl_decode
  import arith_ctrl_pkg::*;
(
  input  logic [3:0] opcode_i,
  input  logic       halt_bit_i,
  output dec_t       dec_o
);

  // Opcode to control-field lookup; every field defaults to zero (NOP)
  always_comb begin
    dec_o = '0;
    case (opcode_i)
      OP_NOP: dec_o = '0;
      OP_LDR: begin dec_o.asel0 = SEL0_R;   dec_o.writes_a = 1'b1; end
      OP_LDM: begin dec_o.asel0 = SEL0_M;   dec_o.writes_a = 1'b1; dec_o.is_ldm = 1'b1; end
      OP_LDI: begin dec_o.asel0 = SEL0_IMM; dec_o.writes_a = 1'b1; end
      OP_AND: begin dec_o.asel0 = SEL0_AND; dec_o.writes_a = 1'b1; end
      OP_OR:  begin dec_o.asel0 = SEL0_OR;  dec_o.writes_a = 1'b1; end
      OP_ADD: begin dec_o.asel0 = SEL0_ADD; dec_o.writes_a = 1'b1; end
      OP_SUB: begin dec_o.asel0 = SEL0_SUB; dec_o.writes_a = 1'b1; end
      OP_IN:  begin dec_o.asel0 = SEL0_IN;  dec_o.writes_a = 1'b1; end
      OP_NOT: begin dec_o.asel1 = SEL1_NOT; dec_o.writes_a = 1'b1; dec_o.use_out2 = 1'b1; end
      OP_INC: begin dec_o.asel1 = SEL1_INC; dec_o.writes_a = 1'b1; dec_o.use_out2 = 1'b1; end
      OP_DEC: begin dec_o.asel1 = SEL1_DEC; dec_o.writes_a = 1'b1; dec_o.use_out2 = 1'b1; end
      OP_SHL: begin dec_o.asel1 = SEL1_SHL; dec_o.writes_a = 1'b1; dec_o.use_out2 = 1'b1; end
      OP_SHR: begin dec_o.asel1 = SEL1_SHR; dec_o.writes_a = 1'b1; dec_o.use_out2 = 1'b1; end
      OP_ROR: begin dec_o.asel1 = SEL1_ROR; dec_o.writes_a = 1'b1; dec_o.use_out2 = 1'b1; end
      OP_SYS: begin
        if (halt_bit_i) begin
          dec_o.is_hlt = 1'b1;
        end else begin
`ifdef ARITH_CTRL_JZ_EN
          dec_o.is_jz = 1'b1;
`else
          dec_o.is_jz = 1'b0;
`endif
        end
      end
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/arith_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : arith_ctrl
// Description : Instruction sequencer for the 16-bit accumulator datapath.
//               Fetches instructions over a req/ack port, decodes them into
//               the datapath selects and writes results back into A.
//               Macro ARITH_CTRL_JZ_EN: enables the conditional jump (JZ);
//               when undefined that encoding is a NOP and no zero detect
//               on A is built.
// Revision    : 1.0 - initial release
// ============================================================================
module arith_ctrl
  import arith_ctrl_pkg::*;
#(
  parameter int PC_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start_i,
  output logic              mem_req_o,
  output logic [PC_W-1:0]   mem_addr_o,
  input  logic              mem_ack_i,
  input  logic [DATA_W-1:0] mem_rdata_i,
  output logic [DATA_W-1:0] a_out_o,
  output logic [DATA_W-1:0] m_out_o,
  output logic [IMM_W-1:0]  imm_out_o,
  output logic [2:0]        asel0_o,
  output logic [2:0]        asel1_o,
  input  logic [DATA_W-1:0] out1_i,
  input  logic [DATA_W-1:0] out2_i,
  output logic [PC_W-1:0]   pc_o,
  output logic              busy_o,
  output logic              halted_o
);

  state_t              state_q;
  logic [PC_W-1:0]     pc_q;
  logic [DATA_W-1:0]   ir_q;
  logic [DATA_W-1:0]   a_q;
  logic [DATA_W-1:0]   m_q;
  logic [2:0]          asel0_q, asel1_q;
  logic [2:0]          asel0_d, asel1_d;
  logic                mem_req_q;
  logic [PC_W-1:0]     mem_addr_q;
  logic                busy_q, halted_q;

  dec_t                dec;
  logic [PC_W-1:0]     pc_inc;
  logic [PC_W-1:0]     imm_tgt;
  logic                jz_cond;
  logic                jump;
  logic                unused_ir_bits;

  arith_ctrl_decode u_decode (
    .opcode_i   (ir_q[OP_HI:OP_LO]),
    .halt_bit_i (ir_q[HALT_BIT]),
    .dec_o      (dec)
  );

  assign pc_inc         = pc_q + PC_W'(1);
  assign imm_tgt        = ir_q[IMM_HI:IMM_LO];
  assign unused_ir_bits = ^ir_q[HALT_BIT-1:IMM_HI+1];

`ifdef ARITH_CTRL_JZ_EN
  assign jz_cond = (a_q == '0);
`else
  assign jz_cond = 1'b0;
`endif
  assign jump = dec.is_jz & jz_cond;

  // Selects for the coming EXEC: only the field the instruction uses moves
  always_comb begin
    asel0_d = asel0_q;
    asel1_d = asel1_q;
    if (dec.writes_a) begin
      if (dec.use_out2) asel1_d = dec.asel1;
      else              asel0_d = dec.asel0;
    end
  end

  // Sequencer FSM with all architectural registers and registered outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      pc_q       <= '0;
      ir_q       <= '0;
      a_q        <= '0;
      m_q        <= '0;
      asel0_q    <= '0;
      asel1_q    <= '0;
      mem_req_q  <= 1'b0;
      mem_addr_q <= '0;
      busy_q     <= 1'b0;
      halted_q   <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE, ST_HALT: begin
          if (start_i) begin
            state_q    <= ST_FETCH;
            mem_req_q  <= 1'b1;
            mem_addr_q <= pc_q;
            busy_q     <= 1'b1;
            halted_q   <= 1'b0;
          end
        end
        ST_FETCH: begin
          if (mem_ack_i) begin
            ir_q      <= mem_rdata_i;
            pc_q      <= pc_inc;
            mem_req_q <= 1'b0;
            state_q   <= ST_DECODE;
          end
        end
        ST_DECODE: begin
          if (dec.is_ldm) begin
            state_q    <= ST_MEMRD;
            mem_req_q  <= 1'b1;
            mem_addr_q <= imm_tgt;
          end else if (dec.is_hlt) begin
            // A start seen on this edge is deliberately ignored
            state_q  <= ST_HALT;
            busy_q   <= 1'b0;
            halted_q <= 1'b1;
          end else begin
            state_q <= ST_EXEC;
            asel0_q <= asel0_d;
            asel1_q <= asel1_d;
          end
        end
        ST_MEMRD: begin
          if (mem_ack_i) begin
            m_q       <= mem_rdata_i;
            mem_req_q <= 1'b0;
            state_q   <= ST_EXEC;
            asel0_q   <= asel0_d;
            asel1_q   <= asel1_d;
          end
        end
        ST_EXEC: begin
          if (dec.writes_a) begin
            a_q <= dec.use_out2 ? out2_i : out1_i;
          end
          // Next fetch is issued directly, using the jump target if taken
          state_q   <= ST_FETCH;
          mem_req_q <= 1'b1;
          if (jump) begin
            pc_q       <= imm_tgt;
            mem_addr_q <= imm_tgt;
          end else begin
            mem_addr_q <= pc_q;
          end
        end
        default: begin
          state_q   <= ST_IDLE;
          mem_req_q <= 1'b0;
          busy_q    <= 1'b0;
          halted_q  <= 1'b0;
        end
      endcase
    end
  end

  assign mem_req_o  = mem_req_q;
  assign mem_addr_o = mem_addr_q;
  assign a_out_o    = a_q;
  assign m_out_o    = m_q;
  assign imm_out_o  = ir_q[IMM_HI:IMM_LO];
  assign asel0_o    = asel0_q;
  assign asel1_o    = asel1_q;
  assign pc_o       = pc_q;
  assign busy_o     = busy_q;
  assign halted_o   = halted_q;

endmodule
`default_nettype wire

// File: tb/tb_arith_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_arith_ctrl
// Description : Scoreboard bench for arith_ctrl with a program memory model
//               (per-address ack latency) and an arithmetic-unit model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_arith_ctrl;

  localparam logic [15:0] DP_R  = 16'h5A5A;
  localparam logic [15:0] DP_IN = 16'h00C3;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        mem_req;
  logic [7:0]  mem_addr;
  logic        mem_ack;
  logic [15:0] mem_rdata;
  logic [15:0] a_out, m_out;
  logic [7:0]  imm_out;
  logic [2:0]  asel0, asel1;
  logic [15:0] out1, out2;
  logic [7:0]  pc;
  logic        busy, halted;

  logic [15:0] mem [256];
  int          lat [256];

  typedef struct {
    bit          h;
    logic [15:0] a;
    logic [7:0]  pc;
    logic [7:0]  addr;
    int          cyc;
  } ev_t;
  ev_t exp_q[$];

  int n_tests = 0;
  int n_fail  = 0;

  arith_ctrl #(.PC_W(8)) dut (
    .clk         (clk),
    .rst         (rst),
    .start_i     (start),
    .mem_req_o   (mem_req),
    .mem_addr_o  (mem_addr),
    .mem_ack_i   (mem_ack),
    .mem_rdata_i (mem_rdata),
    .a_out_o     (a_out),
    .m_out_o     (m_out),
    .imm_out_o   (imm_out),
    .asel0_o     (asel0),
    .asel1_o     (asel1),
    .out1_i      (out1),
    .out2_i      (out2),
    .pc_o        (pc),
    .busy_o      (busy),
    .halted_o    (halted)
  );

  always #5 clk = ~clk;

  // Arithmetic-unit model
  always_comb begin
    out1 = 16'h0000;
    case (asel0)
      3'd0: out1 = DP_R;
      3'd1: out1 = m_out;
      3'd2: out1 = {8'h00, imm_out};
      3'd3: out1 = a_out & m_out;
      3'd4: out1 = a_out | m_out;
      3'd5: out1 = a_out + m_out;
      3'd6: out1 = a_out - m_out;
      default: out1 = DP_IN;
    endcase
  end

  always_comb begin
    out2 = 16'h0000;
    case (asel1)
      3'd0: out2 = ~a_out;
      3'd1: out2 = a_out + 16'd1;
      3'd2: out2 = a_out - 16'd1;
      3'd3: out2 = {a_out[14:0], 1'b0};
      3'd4: out2 = {1'b0, a_out[15:1]};
      3'd5: out2 = {a_out[0], a_out[15:1]};
      default: out2 = 16'h0000;
    endcase
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, required %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic push(input bit h, input logic [15:0] a, input logic [7:0] p,
                      input logic [7:0] ad, input int c);
    ev_t e;
    e.h = h; e.a = a; e.pc = p; e.addr = ad; e.cyc = c;
    exp_q.push_back(e);
  endtask

  task automatic pulse_start();
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
  endtask

  task automatic wait_halt(input string nm);
    for (int k = 0; k < 3000; k++) begin
      if (halted) break;
      @(negedge clk);
    end
    chk(nm, halted, 1'b1);
  endtask

  // Memory responder: ack after lat[addr] wait cycles
  initial begin
    int cnt;
    cnt = 0; mem_ack = 1'b0; mem_rdata = 16'h0000;
    forever begin
      @(negedge clk);
      if (mem_req && !rst) begin
        if (cnt >= lat[mem_addr]) begin
          mem_ack = 1'b1; mem_rdata = mem[mem_addr]; cnt = 0;
        end else begin
          mem_ack = 1'b0; cnt++;
        end
      end else begin
        mem_ack = 1'b0; cnt = 0;
      end
    end
  end

  // Monitor: every new request or halt entry retires one expected event
  initial begin
    int          cyc;
    bit          p_req, p_halt;
    logic [7:0]  p_addr;
    ev_t         e;
    cyc = 0; p_req = 1'b0; p_halt = 1'b0; p_addr = 8'h00;
    forever begin
      @(negedge clk);
      if (rst) begin
        cyc = 0; p_req = 1'b0; p_halt = 1'b0;
      end else begin
        cyc++;
        if (mem_req && p_req) chk("addr_stable", mem_addr, p_addr);
        if ((mem_req && !p_req) || (halted && !p_halt)) begin
          if (exp_q.size() == 0) begin
            n_tests++; n_fail++;
            $display("FAIL unexpected_event: pc=%h addr=%h, required no event", pc, mem_addr);
          end else begin
            e = exp_q.pop_front();
            chk("ev_halted", halted, e.h);
            chk("ev_a", a_out, e.a);
            chk("ev_pc", pc, e.pc);
            if (!e.h) chk("ev_addr", mem_addr, e.addr);
            if (e.cyc >= 0) chk("ev_cycles", cyc, e.cyc);
          end
          cyc = 0;
        end
        p_req = mem_req; p_halt = halted; p_addr = mem_addr;
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Main stimulus
  initial begin
    logic [15:0] seg1 [10];
    logic [15:0] tail [14];
    logic [15:0] tail_a [11];
    logic [7:0]  b;

    seg1   = '{16'h3012, 16'h2040, 16'h30FF, 16'hA000, 16'h3001,
               16'hE000, 16'h6040, 16'h7040, 16'h3000, 16'hF020};
    tail   = '{16'h3001, 16'hF030, 16'h1000, 16'h4040, 16'h5040, 16'hC000, 16'hD000,
               16'hB000, 16'h9000, 16'h8000, 16'h0000, 16'hF800, 16'h3055, 16'hF800};
    tail_a = '{16'h0001, 16'h0001, 16'h5A5A, 16'h1A4A, 16'hBEEF, 16'h7DDE,
               16'h3EEF, 16'h3EEE, 16'hC111, 16'h00C3, 16'h00C3};
`ifdef ARITH_CTRL_JZ_EN
    b = 8'h20;
`else
    b = 8'd10;
`endif
    for (int i = 0; i < 256; i++) begin mem[i] = 16'h0000; lat[i] = 0; end
    for (int i = 0; i < 10; i++) mem[i] = seg1[i];
    for (int i = 0; i < 14; i++) mem[8'(b + 8'(i))] = tail[i];
    mem[8'h40] = 16'hBEEF;
    lat[8'h40] = 2;

    rst = 1'b1; start = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // Reset values
    chk("rst_pc", pc, 8'h00);
    chk("rst_a", a_out, 16'h0000);
    chk("rst_m", m_out, 16'h0000);
    chk("rst_imm", imm_out, 8'h00);
    chk("rst_asel0", asel0, 3'd0);
    chk("rst_asel1", asel1, 3'd0);
    chk("rst_req", mem_req, 1'b0);
    chk("rst_addr", mem_addr, 8'h00);
    chk("rst_busy", busy, 1'b0);
    chk("rst_halted", halted, 1'b0);

    // Segment 1: main program up to the first HLT
    push(0, 16'h0000, 8'h00, 8'h00, -1);
    push(0, 16'h0012, 8'h01, 8'h01, 3);
    push(0, 16'h0012, 8'h02, 8'h40, 2);
    push(0, 16'hBEEF, 8'h02, 8'h02, 4);
    push(0, 16'h00FF, 8'h03, 8'h03, 3);
    push(0, 16'h0100, 8'h04, 8'h04, 3);
    push(0, 16'h0001, 8'h05, 8'h05, 3);
    push(0, 16'h8000, 8'h06, 8'h06, 3);
    push(0, 16'h3EEF, 8'h07, 8'h07, 3);
    push(0, 16'h8000, 8'h08, 8'h08, 3);
    push(0, 16'h0000, 8'h09, 8'h09, 3);
    push(0, 16'h0000, b, b, 3);
    for (int i = 0; i < 11; i++) push(0, tail_a[i], 8'(b + 8'(i + 1)), 8'(b + 8'(i + 1)), 3);
    push(1, 16'h00C3, 8'(b + 8'd12), 8'h00, 2);
    pulse_start();
    wait_halt("halt1_reached");
    repeat (6) @(negedge clk);
    chk("halt1_halted", halted, 1'b1);
    chk("halt1_busy", busy, 1'b0);
    chk("halt1_req", mem_req, 1'b0);
    chk("halt1_pc", pc, 8'(b + 8'd12));

    // Segment 2: resume from HALT at the current pc
    push(0, 16'h00C3, 8'(b + 8'd12), 8'(b + 8'd12), -1);
    push(0, 16'h0055, 8'(b + 8'd13), 8'(b + 8'd13), 3);
    push(1, 16'h0055, 8'(b + 8'd14), 8'h00, 2);
    pulse_start();
    wait_halt("halt2_reached");

    // Segment 3: NOP run through pc wrap, then stall the fetch at 0
    mem[8'h40] = 16'h0000;
    lat[8'h40] = 0;
    lat[0]     = 255;
    push(0, 16'h0055, 8'(b + 8'd14), 8'(b + 8'd14), -1);
    for (int p = int'(b) + 14; p <= 255; p++) push(0, 16'h0055, 8'(p + 1), 8'(p + 1), 3);
    pulse_start();
    for (int k = 0; k < 1500; k++) begin
      if (mem_req && mem_addr == 8'h00 && pc == 8'h00) break;
      @(negedge clk);
    end
    chk("wrap_pc", pc, 8'h00);
    repeat (2) @(negedge clk);
    chk("stall_req", mem_req, 1'b1);

    // Asynchronous reset in the middle of a stalled fetch
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    chk("arst_req", mem_req, 1'b0);
    chk("arst_pc", pc, 8'h00);
    chk("arst_a", a_out, 16'h0000);
    chk("arst_m", m_out, 16'h0000);
    chk("arst_asel0", asel0, 3'd0);
    chk("arst_busy", busy, 1'b0);
    chk("arst_halted", halted, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    chk("idle_req", mem_req, 1'b0);
    chk("idle_busy", busy, 1'b0);
    chk("idle_pc", pc, 8'h00);
    chk("queue_drained", exp_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/arith_ctrl.md
# arith_ctrl

Instruction sequencer for the 16-bit accumulator datapath. Fetches 16-bit instructions from program memory over a req/ack handshake and decodes them into the arithmetic unit's two select fields. It owns the accumulator A, and writes the selected arithmetic result back into A. It sits between program memory and the arithmetic unit and is the only writer of A.

## Interface
- `PC_W`, 8, program counter / memory address width (fixed by the 8-bit immediate field)
- `clk`  in  1  sole clock, rising edge
- `rst`  in  1  asynchronous, active-high reset
- `start`  in  1  leave IDLE/HALT and begin fetching; ignored in other states
- `mem_req`  out  1  memory read request
- `mem_addr`  out  8  read address; stable while `mem_req` high
- `mem_ack`  in  1  read data valid this cycle; ignored when `mem_req` low
- `mem_rdata`  in  16  read data
- `a_out`  out  16  accumulator A, drives the datapath A input
- `m_out`  out  16  latched memory operand, drives the datapath M input
- `imm_out`  out  8  IR[7:0], drives the datapath immediate input
- `asel0`  out  3  primary select (0 R, 1 M, 2 imm, 3 and, 4 or, 5 add, 6 sub, 7 input)
- `asel1`  out  3  unary select (0 not, 1 inc, 2 dec, 3 shl, 4 shr, 5 ror)
- `out1`, `out2`  in  16 each  datapath results
- `pc`  out  8  program counter
- `busy`  out  1  high in any state except IDLE and HALT
- `halted`  out  1  high in HALT

## Operation
- Instruction format: IR[15:12] opcode, IR[11] halt bit, IR[7:0] imm/address.
- Opcodes:
  - 0 NOP
  - 1 LDR A←out1, asel0=0
  - 2 LDM: read M[imm], then A←out1, asel0=1
  - 3 LDI: A←out1, asel0=2
  - 4 AND, 5 OR, 6 ADD, 7 SUB: asel0=3..6, A←out1
  - 8 IN: asel0=7, A←out1
  - 9 NOT, A INC, B DEC, C SHL, D SHR, E ROR: asel1=0..5, A←out2
  - F with IR[11]=1: HLT
  - F with IR[11]=0: JZ imm
- States: IDLE, FETCH, DECODE, MEMRD, EXEC, HALT.
  - IDLE: `start` → FETCH.
  - FETCH: `mem_req`=1, `mem_addr`=pc. On `mem_ack`, IR←mem_rdata, pc←pc+1, go to DECODE.
  - DECODE: LDM → MEMRD; HLT → HALT; all others → EXEC.
  - MEMRD: `mem_req`=1, `mem_addr`=IR[7:0]. On `mem_ack`, m_out←mem_rdata, go to EXEC.
  - EXEC: drive asel0/asel1 from IR, capture result into A at the closing edge, then → FETCH. NOP and JZ do not write A.
  - JZ: if A==0, pc←imm in EXEC; otherwise pc is unchanged (already incremented).
  - HALT: `start` → FETCH at the current pc.
- pc wraps 8'hFF→8'h00, both on increment and as a jump target.
- Selects hold their last value outside EXEC. A changes only in EXEC.

## Timing
- Reset values: pc=0, A=0, m_out=0, IR=0 (so imm_out=0), asel0=0, asel1=0, mem_req=0, mem_addr=0, busy=0, halted=0, state=IDLE.
- Reset is asynchronous. Asserting it mid-operation drops `mem_req` immediately, without waiting for a clock edge. Any in-flight ack is discarded.
- With zero-wait memory (ack in the same cycle as req), ALU and JZ instructions take 3 cycles (FETCH, DECODE, EXEC) and LDM takes 4. Each wait cycle on a read adds one cycle.
- `start` asserted on the same edge as HLT decode: the block still enters HALT. `start` must be asserted again to resume.
- Back-to-back: FETCH of the next instruction follows EXEC directly, with no idle cycle.

## Configuration
- `ARITH_CTRL_JZ_EN`
  - Defined: opcode F with IR[11]=0 performs JZ as described.
  - Undefined: that encoding executes as a NOP (pc+1, A unchanged) and no zero-detect logic is built.
- HLT is present in both builds.

## Structure
- Package `arith_ctrl_pkg` holds:
  - opcode localparams
  - state encoding
  - asel0/asel1 code constants
  - instruction field positions
- Sub-module `arith_ctrl_decode` is combinational: opcode maps to {asel0, asel1, use_out2, writes_a, is_ldm, is_hlt, is_jz}.
- The FSM, pc, IR, A and m_out registers live in the top level.

## Test plan
- Reset, then release; program[0]=16'h3012, zero-wait memory; `start` pulse → A=16'h0012 after 3 cycles, pc=1, all reset values correct before `start`.
- LDM with program[0]=16'h2040, M[0x40]=16'hBEEF, ack delayed 2 cycles → second request with mem_addr=8'h40 held stable during the wait, A=16'hBEEF.
- Boundary checks:
  - LDI 0xFF then INC 16'hA000 → A=16'h0100.
  - LDI 0x01 then ROR 16'hE000 → A=16'h8000.
  - pc at 8'hFF after fetch → pc=8'h00.
- JZ checks:
  - With macro, A=0 and 16'hF020 → pc=8'h20.
  - With macro, A=1 → pc advances by 1.
  - Without macro → pc advances by 1 and A is unchanged.
- HLT 16'hF800 → halted=1, busy=0, mem_req=0 indefinitely; `start` → fetch at pc=1.
- Assert `rst` mid-FETCH while mem_req=1 and ack withheld → mem_req=0 before the next clock edge, pc=0, A=0, state IDLE.
